seq_compare: RTL and testbench
==============================

# seq_compare

Multicycle magnitude comparator for the multicycle datapath. It is the MSB-first counterpart to the combinational ripple set-less-than: it scans operands from the most significant chunk down, C bits per cycle, and stops at the first differing chunk. It produces less-than, equal and an SLT result word. The controller uses it on paths where a full-width combinational compare does not fit the cycle budget.

## Interface
- W, 32, operand width; must be a multiple of C
- C, 4, bits compared per cycle; W/C scan cycles worst case
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  W  operand A; sampled with start
- b  in  W  operand B; sampled with start
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start
- busy  out  1  high while scanning
- done  out  1  one-cycle pulse; result valid
- lt  out  1  a < b
- eq  out  1  a == b
- slt  out  W  {(W-1)'b0, lt}

## Operation
- States:
  - IDLE: start=1 latches a, b and is_signed, sets chunk index k = W/C-1, and moves to SCAN.
  - SCAN: compares chunk k (bits [k*C+C-1 : k*C]).
  - DONE: lasts one cycle, then IDLE.
- Signed mode: bit W-1 of both latched operands is inverted at latch time. An unsigned compare of the modified values then equals the signed compare.
- SCAN step, unsigned C-bit compare of chunk k:
  - Chunks differ: lt_next = (a_k < b_k), eq_next = 0, go to DONE.
  - Chunks equal and k == 0: lt_next = 0, eq_next = 1, go to DONE.
  - Otherwise: k decrements and the block stays in SCAN.
- lt, eq and slt are registered. They update on entry to DONE and hold until the next DONE.
- In DONE, start=1 is accepted exactly as in IDLE (back-to-back operation). In SCAN, start is ignored.
- a, b and is_signed may change freely after the start cycle.
- Reset (rst_n=0 at a clock edge) applies in any state, including mid-SCAN:
  - State returns to IDLE.
  - busy = done = lt = eq = 0 and slt = 0.
  - No done pulse is issued for the aborted operation.

## Timing
- Cycle 0: start sampled.
- Cycles 1..j: busy = 1, where j is the number of chunks scanned (1 ≤ j ≤ W/C).
- Cycle j+1: done = 1 and busy = 0; results are visible in this same cycle.
- Latency with early exit: 2 cycles (top chunk differs) to W/C+1 cycles (differ in chunk 0, or equal).
- Throughput: a new start in the DONE cycle gives its next SCAN in the following cycle.
- busy and done are never high together.
- done is registered; there is no combinational path from inputs to outputs.

## Configuration
- SEQ_COMPARE_EARLY_EXIT_EN defined: the block moves to DONE at the first differing chunk, as described above.
- Not defined:
  - SCAN always runs all W/C chunks.
  - The first differing chunk's outcome is recorded in a sticky "decided" flag; later chunks do not overwrite it.
  - done always arrives at cycle W/C+1, giving constant latency for the controller's fixed-cycle schedule.
  - Results are identical to the early-exit build.

## Test plan
- Unsigned, W=32, C=4: a=0x0000_0005, b=0x0000_0007 -> lt=1, eq=0, slt=0x0000_0001, done in cycle 9.
- a=0xFFFF_FFFF, b=0x0000_0001:
  - is_signed=1 -> lt=1; is_signed=0 -> lt=0, eq=0.
  - done in cycle 2 with SEQ_COMPARE_EARLY_EXIT_EN, cycle 9 without.
- Signed a=b=0x8000_0000 -> eq=1, lt=0, slt=0, done in cycle 9. Prior results hold unchanged until that pulse.
- Protocol:
  - start pulsed during SCAN -> ignored; exactly one done pulse, with results for the first operands.
  - start in the DONE cycle with a=3, b=2 -> second done with lt=0, eq=0.
- rst_n=0 in cycle 3 of a scan -> from the next cycle busy=0, lt=eq=0, slt=0, and no done pulse follows.
- W=8, C=8, signed: a=0x80, b=0x7F -> lt=1, slt=0x01, done in cycle 2 in both builds.

Source files
------------

// File: rtl/seq_compare.sv
// rtl/seq_compare.sv - MSB-first multicycle magnitude comparator (lt / eq / slt)
//
// Scans the latched operands C bits per cycle, from the top chunk down.
// Signed compares invert bit W-1 of both operands at latch time, so the scan
// itself is always an unsigned compare.
//
// Build option: SEQ_COMPARE_EARLY_EXIT_EN
//   defined   - finish at the first differing chunk (latency 2 .. W/C+1)
//   undefined - always scan all W/C chunks (latency fixed at W/C+1); the
//               first differing chunk is held in a sticky decided flag
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      request, accepted in IDLE or DONE
//   a, b       operands [W-1:0], sampled with start
//   is_signed  1 = two's-complement compare, sampled with start
//   busy       high while scanning
//   done       one-cycle result-valid pulse
//   lt, eq     registered a<b / a==b, held until the next done
//   slt        {(W-1)'b0, lt}

module seq_compare #(
   parameter int W = 32,
   parameter int C = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         is_signed,
   output logic         busy,
   output logic         done,
   output logic         lt,
   output logic         eq,
   output logic [W-1:0] slt
);

   localparam int N  = W / C;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [KW-1:0]  k_q, k_d;
   logic           lt_q, lt_d;
   logic           eq_q, eq_d;
   logic [C-1:0]   chunk_a, chunk_b;
   logic           chunk_diff;
   logic           accept;

`ifndef SEQ_COMPARE_EARLY_EXIT_EN
   logic           dec_q, dec_d;        // a differing chunk has been seen
   logic           dec_lt_q, dec_lt_d;  // outcome of that first differing chunk
`endif

   assign accept = start && (state_q == IDLE || state_q == DONE);

   always_comb begin
      chunk_a    = a_q[int'(k_q) * C +: C];
      chunk_b    = b_q[int'(k_q) * C +: C];
      chunk_diff = (chunk_a != chunk_b);
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         k_q      <= '0;
         lt_q     <= 1'b0;
         eq_q     <= 1'b0;
`ifndef SEQ_COMPARE_EARLY_EXIT_EN
         dec_q    <= 1'b0;
         dec_lt_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         k_q      <= k_d;
         lt_q     <= lt_d;
         eq_q     <= eq_d;
`ifndef SEQ_COMPARE_EARLY_EXIT_EN
         dec_q    <= dec_d;
         dec_lt_q <= dec_lt_d;
`endif
      end
   end

   // next-state and datapath
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
`ifndef SEQ_COMPARE_EARLY_EXIT_EN
      dec_d    = dec_q;
      dec_lt_d = dec_lt_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            state_d = accept ? SCAN : IDLE;
            if (accept) begin
               // MSB flip maps two's-complement order onto unsigned order
               a_d = a ^ {is_signed, {(W-1){1'b0}}};
               b_d = b ^ {is_signed, {(W-1){1'b0}}};
               k_d = KW'(N - 1);
`ifndef SEQ_COMPARE_EARLY_EXIT_EN
               dec_d    = 1'b0;
               dec_lt_d = 1'b0;
`endif
            end
         end
         SCAN: begin
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
            if (chunk_diff) begin
               state_d = DONE;
               lt_d    = (chunk_a < chunk_b);
               eq_d    = 1'b0;
            end else if (k_q == '0) begin
               state_d = DONE;
               lt_d    = 1'b0;
               eq_d    = 1'b1;
            end else begin
               k_d = k_q - 1'b1;
            end
`else
            if (!dec_q && chunk_diff) begin
               dec_d    = 1'b1;
               dec_lt_d = (chunk_a < chunk_b);
            end
            if (k_q == '0) begin
               state_d = DONE;
               lt_d    = dec_q ? dec_lt_q : (chunk_diff && (chunk_a < chunk_b));
               eq_d    = !dec_q && !chunk_diff;
            end else begin
               k_d = k_q - 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // outputs decode registered state only
   always_comb begin
      busy = (state_q == SCAN);
      done = (state_q == DONE);
      lt   = lt_q;
      eq   = eq_q;
      slt  = {{(W-1){1'b0}}, lt_q};
   end

endmodule

// File: tb/tb_seq_compare.sv
// tb/tb_seq_compare.sv - self-checking bench for seq_compare
module tb_seq_compare;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] a, b;
   logic        is_signed;
   logic        busy, done, lt, eq;
   logic [31:0] slt;

   logic        start8;
   logic [7:0]  a8, b8;
   logic        s8;
   logic        busy8, done8, lt8, eq8;
   logic [7:0]  slt8;

   int tests = 0;
   int fails = 0;
   logic prev_lt, prev_eq;

   always #5 clk = ~clk;

   seq_compare #(.W(32), .C(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .is_signed(is_signed),
      .busy(busy), .done(done), .lt(lt), .eq(eq), .slt(slt)
   );

   seq_compare #(.W(8), .C(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .is_signed(s8),
      .busy(busy8), .done(done8), .lt(lt8), .eq(eq8), .slt(slt8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One operation: expectations come from plain signed/unsigned arithmetic
   // and from locating the highest differing nibble.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                         input bit pulse_mid);
      logic exp_lt, exp_eq;
      int   j, cyc;
      bit   got;
      exp_lt = ts ? ($signed(ta) < $signed(tb_)) : (ta < tb_);
      exp_eq = (ta == tb_);
      j = N;
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
      for (int m = N - 1; m >= 0; m--) begin
         if (((ta >> (m * 4)) & 32'hF) != ((tb_ >> (m * 4)) & 32'hF)) begin
            j = N - m;
            break;
         end
      end
`endif
      start = 1'b1; a = ta; b = tb_; is_signed = ts;
      cyc = 0; got = 0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done) got = 1;
         else begin
            chk("busy_scan", {31'b0, busy}, 32'd1);
            chk("lt_hold", {31'b0, lt}, {31'b0, prev_lt});
            chk("eq_hold", {31'b0, eq}, {31'b0, prev_eq});
         end
         // operands are free to change after the start cycle
         a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
         if (pulse_mid && cyc == 1) start = 1'b1;
         else start = 1'b0;
      end
      chk("done_seen", {31'b0, got}, 32'd1);
      chk("done_cycle", cyc, j + 1);
      chk("busy_at_done", {31'b0, busy}, 32'd0);
      chk("lt", {31'b0, lt}, {31'b0, exp_lt});
      chk("eq", {31'b0, eq}, {31'b0, exp_eq});
      chk("slt", slt, {31'b0, exp_lt});
      prev_lt = exp_lt;
      prev_eq = exp_eq;
   endtask

   initial begin
      int cyc;
      bit got;
      logic [31:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
      prev_lt = 1'b0; prev_eq = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_lt", {31'b0, lt}, 32'd0);
      chk("rst_eq", {31'b0, eq}, 32'd0);
      chk("rst_slt", slt, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed cases
      run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 0);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
      @(negedge clk);
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
      // start pulsed during SCAN is ignored
      run_op(32'h1234_5678, 32'h1234_5679, 1'b0, 1);
      @(negedge clk);
      chk("single_done", {31'b0, done}, 32'd0);
      // back-to-back: second start issued in the DONE cycle
      run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 0);
      run_op(32'd3, 32'd2, 1'b0, 0);

      // reset mid-scan
      @(negedge clk);
      start = 1'b1; a = 32'd5; b = 32'd7; is_signed = 1'b0;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_lt", {31'b0, lt}, 32'd0);
      chk("abort_eq", {31'b0, eq}, 32'd0);
      chk("abort_slt", slt, 32'd0);
      got = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) got = 1;
      end
      chk("abort_no_done", {31'b0, got}, 32'd0);
      prev_lt = 1'b0; prev_eq = 1'b0;

      // randomized operands, biased towards shared upper chunks
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 2))
            0: rb = $urandom;
            1: rb = ra ^ (32'h1 << $urandom_range(0, 31));
            default: rb = ra;
         endcase
         run_op(ra, rb, $urandom_range(0, 1), i[0]);
      end

      // single-chunk instance, signed
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h80; b8 = 8'h7F; s8 = 1'b1;
      cyc = 0; got = 0;
      while (!got && cyc < 10) begin
         @(negedge clk);
         start8 = 1'b0;
         cyc++;
         if (done8) got = 1;
      end
      chk("w8_done_seen", {31'b0, got}, 32'd1);
      chk("w8_done_cycle", cyc, 32'd2);
      chk("w8_lt", {31'b0, lt8}, 32'd1);
      chk("w8_eq", {31'b0, eq8}, 32'd0);
      chk("w8_slt", {24'b0, slt8}, 32'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
